// File: rtl/demux_de_control_pkg.sv
// Shared K-character map and FSM state for the control-symbol mux/demux pair.
package demux_de_control_pkg;

  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_PAD = 8'hF7;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_STP = 8'hFB;
  localparam logic [7:0] K_SDP = 8'h5C;
  localparam logic [7:0] K_END = 8'hFD;
  localparam logic [7:0] K_EDB = 8'hFE;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;
  localparam logic [7:0] K_RSV = 8'hFF;

  localparam logic [3:0] C_COM = 4'd0;
  localparam logic [3:0] C_PAD = 4'd1;
  localparam logic [3:0] C_SKP = 4'd2;
  localparam logic [3:0] C_STP = 4'd3;
  localparam logic [3:0] C_SDP = 4'd4;
  localparam logic [3:0] C_END = 4'd5;
  localparam logic [3:0] C_EDB = 4'd6;
  localparam logic [3:0] C_FTS = 4'd7;
  localparam logic [3:0] C_IDL = 4'd8;
  localparam logic [3:0] C_RSV = 4'd9;
  localparam logic [3:0] C_UNK = 4'hF;

  typedef enum logic [1:0] {
    ST_UNALIGNED,
    ST_IDLE,
    ST_TLP,
    ST_DLLP
  } state_t;

endpackage

// File: rtl/demux_de_control_decodificador_k.sv
// Combinational K-byte to control-code decoder; known=0 flags a byte outside the map.
module decodificador_k
  import demux_de_control_pkg::*;
(
  input  logic [7:0] sym,
  output logic [3:0] code,
  output logic       known
);

  always_comb begin
    known = 1'b1;
    code  = C_UNK;
    case (sym)
      K_COM:   code = C_COM;
      K_PAD:   code = C_PAD;
      K_SKP:   code = C_SKP;
      K_STP:   code = C_STP;
      K_SDP:   code = C_SDP;
      K_END:   code = C_END;
      K_EDB:   code = C_EDB;
      K_FTS:   code = C_FTS;
      K_IDL:   code = C_IDL;
      K_RSV:   code = C_RSV;
      default: known = 1'b0;
    endcase
  end

endmodule

// File: rtl/demux_de_control.sv
// Receive-side control demux: K decode, COM alignment, and STP/SDP..END/EDB packet framing.
module demux_de_control
  import demux_de_control_pkg::*;
#(
  parameter int ALIGN_COMS = 2,
  parameter int MAX_LEN    = 64,
  parameter int DLLP_LEN   = 6,
  parameter int ERR_LIMIT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] in,
  input  logic       is_k,
  output logic [3:0] control,
  output logic       control_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sop,
  output logic       eop,
  output logic       pkt_good,
  output logic       pkt_type,
  output logic       aligned,
  output logic       error
);

  localparam logic [3:0]  ALIGN_N = 4'(ALIGN_COMS);
  localparam logic [3:0]  ERR_N   = 4'(ERR_LIMIT);
  localparam logic [11:0] LEN_MAX = 12'(MAX_LEN);
  localparam logic [11:0] DLLP_N  = 12'(DLLP_LEN);

  state_t      state;
  logic [3:0]  com_cnt;
  logic [3:0]  err_cnt;
  logic [11:0] len;
  logic [3:0]  code;
  logic        known;
  logic        good_end;
  logic        err_now;
  logic        lose;

  decodificador_k u_dec (.sym(in), .code(code), .known(known));

  always_comb begin
    good_end = (len != 12'd0) && !(state == ST_DLLP && len != DLLP_N);
    err_now  = 1'b0;
    if (valid) begin
      case (state)
        ST_IDLE:         err_now = !is_k || !known || code == C_END || code == C_EDB;
        ST_TLP, ST_DLLP: err_now = is_k ? !(code inside {C_SKP, C_END, C_EDB}) : (len == LEN_MAX);
        default:         err_now = 1'b0;
      endcase
    end
    // an abort already closes any open packet, so losing alignment needs no extra EOP
    lose = err_now && (err_cnt + 4'd1 == ERR_N);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_UNALIGNED;
      com_cnt       <= '0;
      err_cnt       <= '0;
      len           <= '0;
      control       <= '0;
      control_valid <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      sop           <= 1'b0;
      eop           <= 1'b0;
      pkt_good      <= 1'b0;
      pkt_type      <= 1'b0;
      aligned       <= 1'b0;
      error         <= 1'b0;
    end else begin
      control_valid <= 1'b0;
      data_valid    <= 1'b0;
      sop           <= 1'b0;
      eop           <= 1'b0;
      pkt_good      <= 1'b0;
      error         <= 1'b0;
      if (valid) begin
        if (is_k) begin
          control       <= code;
          control_valid <= 1'b1;
        end
        error <= err_now;
        if (err_now)
          err_cnt <= lose ? 4'd0 : err_cnt + 4'd1;
        case (state)
          ST_UNALIGNED: begin
            if (is_k && code == C_COM) begin
              if (com_cnt + 4'd1 == ALIGN_N) begin
                state   <= ST_IDLE;
                aligned <= 1'b1;
                com_cnt <= '0;
              end else begin
                com_cnt <= com_cnt + 4'd1;
              end
            end else begin
              com_cnt <= '0;
            end
          end
          ST_IDLE: begin
            if (is_k && (code == C_STP || code == C_SDP)) begin
              state    <= (code == C_STP) ? ST_TLP : ST_DLLP;
              sop      <= 1'b1;
              pkt_type <= (code == C_SDP);
              len      <= '0;
            end
          end
          default: begin
            if (!is_k) begin
              if (len == LEN_MAX) begin
                eop   <= 1'b1;
                state <= ST_IDLE;
              end else begin
                data_out   <= in;
                data_valid <= 1'b1;
                len        <= len + 12'd1;
              end
            end else if (code != C_SKP) begin
              eop   <= 1'b1;
              state <= ST_IDLE;
              if (code == C_END) begin
                pkt_good <= good_end;
                if (good_end) err_cnt <= '0;
              end
            end
          end
        endcase
        if (lose) begin
          state   <= ST_UNALIGNED;
          aligned <= 1'b0;
          com_cnt <= '0;
        end
      end
    end
  end

endmodule
